// File: rtl/tdm_demux4_pkg.sv
// Shared encodings for the 4-lane TDM receiver: lane indices and the frame FSM states.
package tdm_demux4_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [1:0] LANE_A = 2'b00;
  localparam logic [1:0] LANE_B = 2'b01;
  localparam logic [1:0] LANE_C = 2'b10;
  localparam logic [1:0] LANE_D = 2'b11;

endpackage

// File: rtl/tdm_demux4_demux4.sv
// 1-to-4 decoder: steers a single write strobe onto the output selected by control.
import tdm_demux4_pkg::*;

module demux4 (
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  input  logic       in,
  input  logic [1:0] control
);

  always_comb begin
    out0 = 1'b0;
    out1 = 1'b0;
    out2 = 1'b0;
    out3 = 1'b0;
    case (control)
      LANE_A:  out0 = in;
      LANE_B:  out1 = in;
      LANE_C:  out2 = in;
      LANE_D:  out3 = in;
      default: out0 = 1'b0;
    endcase
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4-lane round-robin link: stages lanes 0..2, publishes the full
// frame on the lane-3 beat, and flags frames cut short by an early start-of-frame.
import tdm_demux4_pkg::*;

module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic [WIDTH-1:0] out_C,
  output logic [WIDTH-1:0] out_D,
  output logic             out_valid,
  output logic [1:0]       lane,
  output logic             err
);

  state_t           r_state;
  logic [1:0]       r_lane;
  logic [WIDTH-1:0] r_s0, r_s1, r_s2;
  logic [WIDTH-1:0] r_outA, r_outB, r_outC, r_outD;
  logic             r_valid, r_err;

  state_t     w_stateNext;
  logic [1:0] w_laneNext;
  logic       w_loadS0, w_wr, w_abort;
  logic       w_en0, w_en1, w_en2, w_complete;

  // Next-state and beat classification; only qualified beats ever move the FSM.
  always_comb begin
    w_stateNext = r_state;
    w_laneNext  = r_lane;
    w_loadS0    = 1'b0;
    w_wr        = 1'b0;
    w_abort     = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          if (in_sof) begin
            w_loadS0    = 1'b1;
            w_laneNext  = LANE_B;
            w_stateNext = COLLECT;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            w_loadS0   = 1'b1;
            w_abort    = 1'b1;
            w_laneNext = LANE_B;
          end else begin
            w_wr = 1'b1;
            if (r_lane == LANE_D) begin
              w_laneNext  = LANE_A;
              w_stateNext = IDLE;
            end else begin
              w_laneNext = r_lane + 2'd1;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Lane 3 strobe doubles as the frame-completion event.
  demux4 u_demux4 (
    .out0    (w_en0),
    .out1    (w_en1),
    .out2    (w_en2),
    .out3    (w_complete),
    .in      (w_wr),
    .control (r_lane)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lane  <= LANE_A;
      r_s0    <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_outA  <= '0;
      r_outB  <= '0;
      r_outC  <= '0;
      r_outD  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_lane  <= w_laneNext;
      r_s0    <= (w_loadS0 | w_en0) ? in_data : r_s0;
      r_s1    <= w_en1 ? in_data : r_s1;
      r_s2    <= w_en2 ? in_data : r_s2;
      r_outA  <= w_complete ? r_s0    : r_outA;
      r_outB  <= w_complete ? r_s1    : r_outB;
      r_outC  <= w_complete ? r_s2    : r_outC;
      r_outD  <= w_complete ? in_data : r_outD;
      r_valid <= w_complete;
      r_err   <= w_abort;
    end
  end

  assign out_A     = r_outA;
  assign out_B     = r_outB;
  assign out_C     = r_outC;
  assign out_D     = r_outD;
  assign out_valid = r_valid;
  assign err       = r_err;
  assign lane      = r_lane;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a table of per-beat vectors with hand-computed
// post-edge outputs, followed by a gapped completion with a bounded wait.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] out_A, out_B, out_C, out_D;
  logic       out_valid, err;
  logic [1:0] lane;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        sof;
    logic [7:0]  data;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[$];

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_A     (out_A),
    .out_B     (out_B),
    .out_C     (out_C),
    .out_D     (out_D),
    .out_valid (out_valid),
    .lane      (lane),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic vld, input logic sof,
                              input logic [7:0] data, input logic [31:0] outs,
                              input logic v, input logic e, input logic [1:0] l);
    vec_t t;
    t.rst  = rst;
    t.vld  = vld;
    t.sof  = sof;
    t.data = data;
    t.exp  = {outs, v, e, l};
    return t;
  endfunction

  // Drive one cycle's inputs away from the edge, then sample just after the edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic sof, input logic [7:0] data);
    @(negedge clk);
    reset    = rst;
    in_valid = vld;
    in_sof   = sof;
    in_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [35:0] expv);
    logic [35:0] act;
    act = {out_A, out_B, out_C, out_D, out_valid, err, lane};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: got ABCD=%h v=%b e=%b lane=%0d, expected ABCD=%h v=%b e=%b lane=%0d",
               name, idx, act[35:4], act[3], act[2], act[1:0], expv[35:4], expv[3], expv[2], expv[1:0]);
    end
  endtask

  initial begin
    // reset, then one frame
    vecs.push_back(mk(1,0,0,8'h00, 32'h00000000,0,0,0));
    vecs.push_back(mk(0,1,1,8'h11, 32'h00000000,0,0,1));
    vecs.push_back(mk(0,1,0,8'h22, 32'h00000000,0,0,2));
    vecs.push_back(mk(0,1,0,8'h33, 32'h00000000,0,0,3));
    vecs.push_back(mk(0,1,0,8'h44, 32'h11223344,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'h11223344,0,0,0));
    // gapped frame; sof without valid in the gaps must be ignored
    vecs.push_back(mk(0,1,1,8'h11, 32'h11223344,0,0,1));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,1,8'hFF, 32'h11223344,0,0,1));
    vecs.push_back(mk(0,1,0,8'h22, 32'h11223344,0,0,2));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,0,8'hEE, 32'h11223344,0,0,2));
    vecs.push_back(mk(0,1,0,8'h33, 32'h11223344,0,0,3));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,1,8'hDD, 32'h11223344,0,0,3));
    vecs.push_back(mk(0,1,0,8'h44, 32'h11223344,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'h11223344,0,0,0));
    // early sof abort
    vecs.push_back(mk(0,1,1,8'hAA, 32'h11223344,0,0,1));
    vecs.push_back(mk(0,1,0,8'hBB, 32'h11223344,0,0,2));
    vecs.push_back(mk(0,1,1,8'h01, 32'h11223344,0,1,1));
    vecs.push_back(mk(0,1,0,8'h02, 32'h11223344,0,0,2));
    vecs.push_back(mk(0,1,0,8'h03, 32'h11223344,0,0,3));
    vecs.push_back(mk(0,1,0,8'h04, 32'h01020304,1,0,0));
    // sof landing on the lane-3 slot
    vecs.push_back(mk(0,1,1,8'h01, 32'h01020304,0,0,1));
    vecs.push_back(mk(0,1,0,8'h02, 32'h01020304,0,0,2));
    vecs.push_back(mk(0,1,0,8'h03, 32'h01020304,0,0,3));
    vecs.push_back(mk(0,1,1,8'h05, 32'h01020304,0,1,1));
    vecs.push_back(mk(0,1,0,8'h06, 32'h01020304,0,0,2));
    vecs.push_back(mk(0,1,0,8'h07, 32'h01020304,0,0,3));
    vecs.push_back(mk(0,1,0,8'h08, 32'h05060708,1,0,0));
    // idle junk, then back-to-back frames
    vecs.push_back(mk(0,1,0,8'h99, 32'h05060708,0,0,0));
    vecs.push_back(mk(0,1,1,8'hA1, 32'h05060708,0,0,1));
    vecs.push_back(mk(0,1,0,8'hA2, 32'h05060708,0,0,2));
    vecs.push_back(mk(0,1,0,8'hA3, 32'h05060708,0,0,3));
    vecs.push_back(mk(0,1,0,8'hA4, 32'hA1A2A3A4,1,0,0));
    vecs.push_back(mk(0,1,1,8'hB1, 32'hA1A2A3A4,0,0,1));
    vecs.push_back(mk(0,1,0,8'hB2, 32'hA1A2A3A4,0,0,2));
    vecs.push_back(mk(0,1,0,8'hB3, 32'hA1A2A3A4,0,0,3));
    vecs.push_back(mk(0,1,0,8'hB4, 32'hB1B2B3B4,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'hB1B2B3B4,0,0,0));
    // reset mid-frame, trailing non-sof beats ignored, fresh sof accepted
    vecs.push_back(mk(0,1,1,8'hC1, 32'hB1B2B3B4,0,0,1));
    vecs.push_back(mk(0,1,0,8'hC2, 32'hB1B2B3B4,0,0,2));
    vecs.push_back(mk(1,1,0,8'hC3, 32'h00000000,0,0,0));
    vecs.push_back(mk(0,1,0,8'hC4, 32'h00000000,0,0,0));
    vecs.push_back(mk(0,1,0,8'hC5, 32'h00000000,0,0,0));
    vecs.push_back(mk(0,1,1,8'hD1, 32'h00000000,0,0,1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].sof, vecs[i].data);
      checkOutput("vec", i, vecs[i].exp);
    end

    // Staging must survive long gaps after the post-reset sof; stage C1/C2 must not leak.
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'hD2);
    checkOutput("gapLaneC", 0, {32'h00000000, 1'b0, 1'b0, 2'd2});
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'hD3);
    applyStimulus(0, 1, 0, 8'hD4);
    begin
      int waited = 0;
      while (out_valid !== 1'b1 && waited < 8) begin
        applyStimulus(0, 0, 0, 8'h00);
        waited++;
      end
      checks++;
      if (waited != 0) begin
        failures++;
        $display("[TB] FAIL validLatency: got %0d extra cycles (out_valid=%b), expected 0", waited, out_valid);
      end
    end
    checkOutput("finalFrame", 0, {32'hD1D2D3D4, 1'b1, 1'b0, 2'd0});
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("pulseDrop", 0, {32'hD1D2D3D4, 1'b0, 1'b0, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receive end of a 4-lane round-robin serial link.
- The sending side drives one lane per beat (lane 0..3 in order), with a start-of-frame marker on lane 0.
- This block rebuilds the 4 parallel words and presents a complete frame with a one-cycle valid pulse.
- It sits between the serial link and any 4-input consumer; internal lane steering is the inverse of a 4:1 select.

Parameters:
- WIDTH, 8, bit width of each lane word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  start of frame; qualified by in_valid; marks the lane-0 beat.
- in_data  input  WIDTH  serial lane word.
- out_A  output  WIDTH  lane 0 word of the last complete frame.
- out_B  output  WIDTH  lane 1 word of the last complete frame.
- out_C  output  WIDTH  lane 2 word of the last complete frame.
- out_D  output  WIDTH  lane 3 word of the last complete frame.
- out_valid  output  1  one-cycle pulse: out_A..out_D just updated.
- lane  output  2  lane index the next non-sof beat will fill (debug/status).
- err  output  1  one-cycle pulse: frame aborted by an early sof.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_A..out_D = 0, out_valid = 0, err = 0, lane = 0.
  - State = IDLE; staging registers S0..S2 = 0.
  - Reset mid-frame discards the partial frame. Outputs clear on the reset edge.
- State IDLE (waiting for frame):
  - in_valid & in_sof: S0 <= in_data, lane <= 1, go to COLLECT.
  - in_valid & !in_sof: beat dropped silently; no err, state unchanged.
  - !in_valid: hold.
- State COLLECT:
  - !in_valid: hold everything. Gaps between beats may be any length.
  - in_valid & !in_sof & lane in {1,2}: S[lane] <= in_data, lane <= lane+1.
  - in_valid & !in_sof & lane == 3 (frame completion):
    - out_A <= S0, out_B <= S1, out_C <= S2, out_D <= in_data.
    - out_valid <= 1 for exactly the next cycle.
    - lane <= 0, go to IDLE.
  - in_valid & in_sof (any lane, including lane 3): abort.
    - err <= 1 for exactly one cycle.
    - S0 <= in_data, lane <= 1, stay in COLLECT.
    - out_A..out_D unchanged; no out_valid.
- Latency and output holding:
  - out_valid and the new outputs appear on the edge that captures the lane-3 beat, so they are visible in the following cycle.
  - out_A..out_D hold their value until the next completion or reset.
- Back-to-back frames:
  - An in_sof beat in the cycle immediately after a completion beat is accepted (state is IDLE by then).
  - Sustained throughput is one frame per 4 cycles.
- out_valid and err are never high in the same cycle. Both deassert on any cycle without their triggering event.
- in_sof without in_valid is ignored in every state.
- The lane counter is 2 bits and never wraps past 3. Completion always resets it to 0.

Decomposition:
- Shared include: lane encodings LANE_A=2'b00, LANE_B=2'b01, LANE_C=2'b10, LANE_D=2'b11, and state encodings IDLE=1'b0, COLLECT=1'b1.
- Sub-module demux4(out0..out3, in, control[1:0]):
  - Combinational 1-to-4 decoder, the structural inverse of mux4.
  - Turns the write strobe plus lane into per-staging-register enables.
- Top level holds:
  - the state flop and lane counter;
  - the staging registers and output registers (enable-gated flops selected with mux2);
  - the pulse logic for out_valid and err.

Test Plan:
- Reset then one frame (WIDTH=8):
  - Stimulus: sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Response: one cycle after the 0x44 beat, out_A..D = 11,22,33,44 and out_valid=1 for 1 cycle; lane returns to 0.
- Gapped frame:
  - Stimulus: same beats with in_valid low for 3 cycles between each.
  - Response: identical outputs; out_valid pulses once; lane steps 1,2,3,0 only on valid beats.
- Early sof abort:
  - Stimulus: sof+0xAA, 0xBB, then sof+0x01, 0x02, 0x03, 0x04.
  - Response: err pulses 1 cycle after the second sof; outputs stay at prior frame until completion, then 01,02,03,04; no out_valid for the aborted frame.
- sof on the lane-3 slot:
  - Stimulus: sof+1, 2, 3, then sof+5.
  - Response: err=1, no out_valid, lane=1; frame 5,6,7,8 then completes normally.
- Idle junk and back-to-back:
  - Stimulus: 0x99 with in_sof=0 while IDLE, then two consecutive frames with no gap.
  - Response: junk ignored with err=0; out_valid high on cycles 5 and 9 counted from the first sof; outputs show frame 1 then frame 2.
- Reset mid-frame:
  - Stimulus: assert reset after 2 beats.
  - Response: next cycle all outputs 0, lane=0, IDLE; the following non-sof beats are ignored.
